// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, response-slot record and the
// slot update rule used by both requester ports of the arbiter.
package alu_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ALU_CTRL_W = 3;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SRA = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] result;
        logic              zero;
    } rsp_slot_t;

    // A refill always wins over a drain, so consume-and-refill never bubbles.
    function automatic rsp_slot_t nextSlot(
        input rsp_slot_t         cur,
        input logic              grant,
        input logic              consume,
        input logic [DATA_W-1:0] result,
        input logic              zero
    );
        rsp_slot_t nxt;
        nxt = cur;
        if (grant) begin
            nxt.valid  = 1'b1;
            nxt.result = result;
            nxt.zero   = zero;
        end else if (consume) begin
            nxt.valid = 1'b0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU shared by the arbiter's two requester ports.
// Shift amounts use the full SrcB value, so amounts of 32 or more saturate.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0]     srcA_i,
    input  logic [DATA_W-1:0]     srcB_i,
    input  logic [ALU_CTRL_W-1:0] aluControl_i,
    output logic [DATA_W-1:0]     aluResult_o,
    output logic                  zero_o
);

    logic [DATA_W-1:0] aluResult;

    always_comb begin
        aluResult = '0;
        case (alu_op_e'(aluControl_i))
            ALU_ADD: aluResult = srcA_i + srcB_i;
            ALU_SUB: aluResult = srcA_i - srcB_i;
            ALU_AND: aluResult = srcA_i & srcB_i;
            ALU_OR:  aluResult = srcA_i | srcB_i;
            ALU_XOR: aluResult = srcA_i ^ srcB_i;
            ALU_SLL: aluResult = srcA_i << srcB_i;
            ALU_SRL: aluResult = srcA_i >> srcB_i;
            ALU_SRA: aluResult = $signed(srcA_i) >>> srcB_i;
            default: aluResult = '0;
        endcase
    end

    assign aluResult_o = aluResult;
    assign zero_o      = (aluResult == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-port front end for one shared ALU: picks at most one request per
// cycle (round-robin or fixed priority) and registers each port's result.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_ctrl,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp0_zero,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_ctrl,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic        rsp1_zero
);

    logic              elig0;
    logic              elig1;
    logic              grant0;
    logic              grant1;
    logic              prio_q;
    logic              prio_d;
    logic [DATA_W-1:0] srcA;
    logic [DATA_W-1:0] srcB;
    logic [2:0]        aluCtrl;
    logic [DATA_W-1:0] aluResult;
    logic              aluZero;
    rsp_slot_t         slot0_q;
    rsp_slot_t         slot0_d;
    rsp_slot_t         slot1_q;
    rsp_slot_t         slot1_d;

    // A port may issue only if its slot is empty or being drained this cycle.
    always_comb begin
        elig0 = req0_valid && (!slot0_q.valid || rsp0_ready);
        elig1 = req1_valid && (!slot1_q.valid || rsp1_ready);
    end

    // Grant depends only on valids, slot state and prio; nothing is granted in reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
            if (elig0 && elig1) begin
                if (RR_EN && prio_q) begin
                    grant1 = 1'b1;
                end else begin
                    grant0 = 1'b1;
                end
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (RR_EN) begin
            if (grant0) begin
                prio_d = 1'b1;
            end else if (grant1) begin
                prio_d = 1'b0;
            end
        end
    end

    always_comb begin
        srcA    = grant1 ? req1_a    : req0_a;
        srcB    = grant1 ? req1_b    : req0_b;
        aluCtrl = grant1 ? req1_ctrl : req0_ctrl;
    end

    alu u_alu (
        .srcA_i       (srcA),
        .srcB_i       (srcB),
        .aluControl_i (aluCtrl),
        .aluResult_o  (aluResult),
        .zero_o       (aluZero)
    );

    always_comb begin
        slot0_d = nextSlot(slot0_q, grant0, rsp0_ready, aluResult, aluZero);
        slot1_d = nextSlot(slot1_q, grant1, rsp1_ready, aluResult, aluZero);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q  <= 1'b0;
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            prio_q  <= prio_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign rsp0_valid  = slot0_q.valid;
    assign rsp0_result = slot0_q.result;
    assign rsp0_zero   = slot0_q.zero;
    assign rsp1_valid  = slot1_q.valid;
    assign rsp1_result = slot1_q.result;
    assign rsp1_zero   = slot1_q.zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a round-robin instance checked against a cycle
// model and result scoreboard, plus a fixed-priority instance on the same inputs.
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] result;
        logic        zero;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
        logic [31:0] expResult;
        logic        expZero;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_ctrl, req1_ctrl;
    logic        rsp0_ready, rsp1_ready;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_zero, rsp1_zero;
    logic        fpReq0Ready, fpReq1Ready, fpRsp0Valid, fpRsp1Valid;
    logic [31:0] fpRsp0Result, fpRsp1Result;
    logic        fpRsp0Zero, fpRsp1Zero;

    int   vectorsApplied = 0;
    int   miscompares    = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic modelValid0 = 1'b0;
    logic modelValid1 = 1'b0;
    logic modelPrio   = 1'b0;
    logic modelKnown  = 1'b0;
    logic useTableExp = 1'b0;
    exp_t tableExp;
    logic dutReady0, dutReady1, dutValid0, dutZero0, dutZero1;
    logic [31:0] dutResult0, dutResult1;
    logic fpReady0, fpReady1, fpValid0;
    logic [31:0] fpResult0;
    vec_t vecTable [13];

    always #5 clk = ~clk;

    alu_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ctrl(req0_ctrl), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ctrl(req1_ctrl), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero)
    );

    alu_arbiter #(.RR_EN(1'b0)) dutFp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fpReq0Ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ctrl(req0_ctrl), .rsp0_valid(fpRsp0Valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(fpRsp0Result), .rsp0_zero(fpRsp0Zero),
        .req1_valid(req1_valid), .req1_ready(fpReq1Ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ctrl(req1_ctrl), .rsp1_valid(fpRsp1Valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(fpRsp1Result), .rsp1_zero(fpRsp1Zero)
    );

    // Reference ALU, written with explicit saturation for shifts of 32 or more.
    function automatic exp_t aluRef(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        exp_t r;
        logic [31:0] res;
        case (alu_op_e'(c))
            ALU_ADD: res = a + b;
            ALU_SUB: res = a + ~b + 32'd1;
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_XOR: res = a ^ b;
            ALU_SLL: res = (b > 32'd31) ? 32'h0 : (a << b[4:0]);
            ALU_SRL: res = (b > 32'd31) ? 32'h0 : (a >> b[4:0]);
            default: res = (b > 32'd31) ? {32{a[31]}} : 32'($signed(a) >>> b[4:0]);
        endcase
        r.result = res;
        r.zero   = (res == 32'h0);
        return r;
    endfunction

    function automatic logic [31:0] randB();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return 32'($urandom_range(0, 40));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectorsApplied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic failNow(input string name);
        vectorsApplied++;
        miscompares++;
        $display("[TB] FAIL %s: scoreboard empty while a response is expected at %0t", name, $time);
    endtask

    task automatic applyStimulus(
        input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] c0,
        input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] c1,
        input logic r0, input logic r1
    );
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctrl = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctrl = c1;
        rsp0_ready = r0; rsp1_ready = r1;
    endtask

    // One clock: sample at the falling edge, compare against the model, advance it.
    task automatic stepCycle();
        logic elig0, elig1, g0, g1;
        @(negedge clk);
        dutReady0 = req0_ready;   dutReady1 = req1_ready;   dutValid0 = rsp0_valid;
        dutResult0 = rsp0_result; dutResult1 = rsp1_result;
        dutZero0 = rsp0_zero;     dutZero1 = rsp1_zero;
        fpReady0 = fpReq0Ready;   fpReady1 = fpReq1Ready;
        fpValid0 = fpRsp0Valid;   fpResult0 = fpRsp0Result;
        elig0 = req0_valid && (!modelValid0 || rsp0_ready);
        elig1 = req1_valid && (!modelValid1 || rsp1_ready);
        if (!rst_n) begin
            g0 = 1'b0; g1 = 1'b0;
        end else if (elig0 && elig1) begin
            g0 = !modelPrio; g1 = modelPrio;
        end else begin
            g0 = elig0; g1 = elig1;
        end
        checkOutput("req0_ready", 32'(req0_ready), 32'(g0));
        checkOutput("req1_ready", 32'(req1_ready), 32'(g1));
        if (modelKnown) begin
            checkOutput("rsp0_valid", 32'(rsp0_valid), 32'(modelValid0));
            checkOutput("rsp1_valid", 32'(rsp1_valid), 32'(modelValid1));
            if (modelValid0) begin
                if (q0.size() == 0) failNow("rsp0_sb");
                else begin
                    checkOutput("rsp0_result", rsp0_result, q0[0].result);
                    checkOutput("rsp0_zero", 32'(rsp0_zero), 32'(q0[0].zero));
                    if (rst_n && rsp0_ready) void'(q0.pop_front());
                end
            end
            if (modelValid1) begin
                if (q1.size() == 0) failNow("rsp1_sb");
                else begin
                    checkOutput("rsp1_result", rsp1_result, q1[0].result);
                    checkOutput("rsp1_zero", 32'(rsp1_zero), 32'(q1[0].zero));
                    if (rst_n && rsp1_ready) void'(q1.pop_front());
                end
            end
        end
        if (g0) q0.push_back(useTableExp ? tableExp : aluRef(req0_a, req0_b, req0_ctrl));
        if (g1) q1.push_back(useTableExp ? tableExp : aluRef(req1_a, req1_b, req1_ctrl));
        if (!rst_n) begin
            modelValid0 = 1'b0; modelValid1 = 1'b0; modelPrio = 1'b0; modelKnown = 1'b1;
            q0.delete(); q1.delete();
        end else begin
            modelValid0 = g0 ? 1'b1 : (rsp0_ready ? 1'b0 : modelValid0);
            modelValid1 = g1 ? 1'b1 : (rsp1_ready ? 1'b0 : modelValid1);
            if (g0) modelPrio = 1'b1;
            else if (g1) modelPrio = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    initial begin
        logic [31:0] pa, pb;
        logic [2:0]  pc;
        logic        prevReady0;
        exp_t        e;

        vecTable[0]  = '{32'd5,        32'd3,        ALU_SUB, 32'd2,        1'b0};
        vecTable[1]  = '{32'hFFFFFFFF, 32'd1,        ALU_ADD, 32'h0,        1'b1};
        vecTable[2]  = '{32'h0,        32'd1,        ALU_SUB, 32'hFFFFFFFF, 1'b0};
        vecTable[3]  = '{32'hF0F0F0F0, 32'hFF00FF00, ALU_AND, 32'hF000F000, 1'b0};
        vecTable[4]  = '{32'hF0F0F0F0, 32'h0F0F0F0F, ALU_OR,  32'hFFFFFFFF, 1'b0};
        vecTable[5]  = '{32'h12345678, 32'h12345678, ALU_XOR, 32'h0,        1'b1};
        vecTable[6]  = '{32'h1,        32'd31,       ALU_SLL, 32'h80000000, 1'b0};
        vecTable[7]  = '{32'h1,        32'd32,       ALU_SLL, 32'h0,        1'b1};
        vecTable[8]  = '{32'h80000000, 32'd4,        ALU_SRL, 32'h08000000, 1'b0};
        vecTable[9]  = '{32'h80000000, 32'd4,        ALU_SRA, 32'hF8000000, 1'b0};
        vecTable[10] = '{32'h80000000, 32'd100,      ALU_SRA, 32'hFFFFFFFF, 1'b0};
        vecTable[11] = '{32'd7,        32'd7,        ALU_SUB, 32'h0,        1'b1};
        vecTable[12] = '{32'h7FFFFFFF, 32'd1,        ALU_ADD, 32'h80000000, 1'b0};

        // Reset with requests presented: they must be dropped.
        rst_n = 1'b0;
        applyStimulus(1, 32'd9, 32'd9, ALU_ADD, 1, 32'd4, 32'd4, ALU_ADD, 1, 1);
        stepCycle();
        stepCycle();
        rst_n = 1'b1;
        idle(1);
        checkOutput("reset_rsp0_result", dutResult0, 32'h0);
        checkOutput("reset_rsp0_zero", 32'(dutZero0), 32'h0);
        checkOutput("reset_rsp1_result", dutResult1, 32'h0);
        checkOutput("reset_rsp1_zero", 32'(dutZero1), 32'h0);

        // Table vectors back-to-back through each port alone (consume and refill each cycle).
        useTableExp = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 13; i++) begin
                tableExp.result = vecTable[i].expResult;
                tableExp.zero   = vecTable[i].expZero;
                if (p == 0) applyStimulus(1, vecTable[i].a, vecTable[i].b, vecTable[i].ctrl, 0, 0, 0, 0, 1, 1);
                else        applyStimulus(0, 0, 0, 0, 1, vecTable[i].a, vecTable[i].b, vecTable[i].ctrl, 1, 1);
                stepCycle();
            end
            idle(1);
        end
        useTableExp = 1'b0;
        idle(1);

        // Both ports busy with free slots: grants must alternate.
        prevReady0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, $urandom, randB(), 3'($urandom_range(0, 7)),
                          1, $urandom, randB(), 3'($urandom_range(0, 7)), 1, 1);
            stepCycle();
            checkOutput("rr_one_grant", 32'(dutReady0 ^ dutReady1), 32'h1);
            if (i > 0) checkOutput("rr_alternate", 32'(dutReady0), 32'(!prevReady0));
            prevReady0 = dutReady0;
        end
        idle(2);

        // Port 1 response held: port 1 stalls, port 0 keeps flowing.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, $urandom, randB(), 3'($urandom_range(0, 7)),
                          1, $urandom, randB(), 3'($urandom_range(0, 7)), 1, 0);
            stepCycle();
            if (i >= 2) begin
                checkOutput("stall_req0_ready", 32'(dutReady0), 32'h1);
                checkOutput("stall_req1_ready", 32'(dutReady1), 32'h0);
            end
        end
        applyStimulus(1, $urandom, randB(), ALU_XOR, 1, $urandom, randB(), ALU_OR, 1, 1);
        stepCycle();
        checkOutput("release_req1_ready", 32'(dutReady1), 32'h1);
        idle(2);

        // Random traffic with random response back-pressure.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, randB(), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), $urandom, randB(), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            stepCycle();
        end
        idle(2);

        // Fixed-priority instance: port 1 never wins while port 0 is eligible.
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, $urandom, randB(), 3'($urandom_range(0, 7)),
                          1, $urandom, randB(), 3'($urandom_range(0, 7)), 1, 1);
            stepCycle();
            checkOutput("fp_req0_ready", 32'(fpReady0), 32'h1);
            checkOutput("fp_req1_ready", 32'(fpReady1), 32'h0);
            if (i > 0) begin
                e = aluRef(pa, pb, pc);
                checkOutput("fp_rsp0_valid", 32'(fpValid0), 32'h1);
                checkOutput("fp_rsp0_result", fpResult0, e.result);
            end
            pa = req0_a; pb = req0_b; pc = req0_ctrl;
        end
        applyStimulus(0, 0, 0, 0, 1, 32'd1, 32'd2, ALU_ADD, 1, 1);
        stepCycle();
        checkOutput("fp_req1_alone", 32'(fpReady1), 32'h1);
        idle(2);

        // Reset pulse while a result is held discards it and re-favours port 0.
        applyStimulus(1, 32'd40, 32'd2, ALU_ADD, 0, 0, 0, 0, 0, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        stepCycle();
        rst_n = 1'b0;
        stepCycle();
        rst_n = 1'b1;
        applyStimulus(1, 32'd8, 32'd1, ALU_SLL, 1, 32'd3, 32'd3, ALU_AND, 1, 1);
        stepCycle();
        checkOutput("rstpulse_rsp0_valid", 32'(dutValid0), 32'h0);
        checkOutput("rstpulse_rsp0_result", dutResult0, 32'h0);
        checkOutput("rstpulse_req0_ready", 32'(dutReady0), 32'h1);
        checkOutput("rstpulse_req1_ready", 32'(dutReady1), 32'h0);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
